// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//   Dynamic branch predictor and flush sequencer for a 5-stage RV32I pipeline.
//   - Fetch side: a direct-mapped BTB with 2-bit saturating counters predicts
//     taken/target for if_pc.
//   - Execute side: resolves conditional branches from BrEq/BrLT and trains the
//     table. On a mispredict it redirects the PC and holds flush for FLUSH_LEN
//     cycles so the wrong-path IF/ID and ID/EX contents are killed.
//
// Parameters
//   IDX_BITS   table index width (2**IDX_BITS entries, index = pc[IDX_BITS+1:2])
//   FLUSH_LEN  cycles flush is held after a mispredict (1..7)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   if_pc               fetch PC
//   pred_taken          prediction for if_pc (combinational)
//   pred_target         predicted next PC (if_pc+4 when not predicted taken)
//   ex_valid            EX holds a valid instruction
//   ex_opcode/funct3    EX instruction decode fields
//   ex_pc, ex_target    PC and computed branch target of the EX instruction
//   ex_pred_taken/
//   ex_pred_target      prediction that travelled down the pipe with it
//   BrEq, BrLT          comparator results for the EX operands
//   flush               kill IF/ID and ID/EX
//   pcsel, redirect_pc  load redirect_pc into PC this cycle
//   br_count            resolved branches (wraps)
//   mispred_count       mispredicted branches (wraps)
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
    parameter int IDX_BITS  = 6,
    parameter int FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic        flush,
    output logic        pcsel,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int          ENTRIES    = 1 << IDX_BITS;
    localparam int          TAG_W      = 30 - IDX_BITS;
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_LEN);

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t     state, state_next;
    logic [2:0] flush_cnt, flush_cnt_next;

    // Prediction table
    logic [ENTRIES-1:0] entry_valid;
    logic [1:0]         entry_ctr    [ENTRIES];
    logic [TAG_W-1:0]   entry_tag    [ENTRIES];
    logic [31:0]        entry_target [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                if_hit, ex_hit;

    logic f3_legal, br_taken, res, mispredict;

    // Byte-offset bits of the PCs carry no information for the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        n = c;
        if (taken && c != 2'b11) n = c + 2'b01;
        else if (!taken && c != 2'b00) n = c - 2'b01;
        return n;
    endfunction

    // ---------------- Fetch-side lookup ----------------
    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[31:IDX_BITS+2];
    assign if_hit = entry_valid[if_idx] && (entry_tag[if_idx] == if_tag);

    assign pred_taken  = if_hit && entry_ctr[if_idx][1];
    assign pred_target = pred_taken ? entry_target[if_idx] : if_pc + 32'd4;

    // ---------------- Execute-side resolve ----------------
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[31:IDX_BITS+2];
    assign ex_hit = entry_valid[ex_idx] && (entry_tag[ex_idx] == ex_tag);

    always_comb begin
        f3_legal = 1'b1;
        br_taken = 1'b0;
        case (ex_funct3)
            3'b000:         br_taken = BrEq;
            3'b001:         br_taken = !BrEq;
            3'b100, 3'b110: br_taken = BrLT;
            3'b101, 3'b111: br_taken = !BrLT;
            default:        f3_legal = 1'b0;
        endcase
    end

    // Branches arriving while flushing are wrong-path and must not train or count.
    assign res = ex_valid && (ex_opcode == OP_BRANCH) && f3_legal && (state == ST_IDLE);
    assign mispredict = (br_taken != ex_pred_taken) ||
                        (br_taken && (ex_pred_target != ex_target));

    // ---------------- Table training ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i] <= 1'b0;
                entry_ctr[i]   <= 2'b01;
            end
        end else if (res) begin
            if (ex_hit) begin
                entry_ctr[ex_idx] <= ctr_next(entry_ctr[ex_idx], br_taken);
            end else if (br_taken) begin
                entry_valid[ex_idx] <= 1'b1;
                entry_ctr[ex_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target are qualified by entry_valid, so they need no reset. Rewriting
    // the tag on a hit stores the same value, which keeps the write path simple.
    always_ff @(posedge clk) begin
        if (res && br_taken) begin
            entry_tag[ex_idx]    <= ex_tag;
            entry_target[ex_idx] <= ex_target;
        end
    end

    // ---------------- Flush sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        flush          = 1'b0;
        pcsel          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (res && mispredict) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                // Counter still at its load value marks the first flush cycle.
                pcsel = (flush_cnt == FLUSH_INIT);
                if (flush_cnt <= 3'd1) begin
                    state_next = ST_IDLE;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Corrected PC captured with the mispredicting branch, presented with pcsel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= 32'd0;
        end else if (res && mispredict) begin
            redirect_pc <= br_taken ? ex_target : ex_pc + 32'd4;
        end
    end

    // ---------------- Statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            br_count      <= br_count + 32'(res);
            mispred_count <= mispred_count + 32'(res && mispredict);
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        BrEq;
    logic        BrLT;
    logic        flush;
    logic        pcsel;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int checks = 0;
    int errors = 0;

    branch_predict_ctrl #(.IDX_BITS(6), .FLUSH_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .BrEq(BrEq), .BrLT(BrLT),
        .flush(flush), .pcsel(pcsel), .redirect_pc(redirect_pc),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt,
                          input logic eq, input logic lt);
        ex_valid       = 1'b1;
        ex_opcode      = op;
        ex_funct3      = f3;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        BrEq           = eq;
        BrLT           = lt;
    endtask

    // Present one EX instruction for exactly one clock edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt,
                         input logic eq, input logic lt);
        set_ex(op, f3, pc, tgt, pt, ptgt, eq, lt);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0; if_pc = 32'h100; ex_valid = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0;
        ex_pc = 32'd0; ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
        BrEq = 1'b0; BrLT = 1'b0;
        #1;
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'h104);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_pcsel", 32'(pcsel), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // BEQ taken, predicted not taken: allocate + redirect to target
        set_ex(OP_BR, 3'b000, 32'h100, 32'h180, 1'b0, 32'h104, 1'b1, 1'b0);
        #1;
        chk("same_cycle_not_visible", 32'(pred_taken), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("beq_pcsel", 32'(pcsel), 32'd1);
        chk("beq_flush", 32'(flush), 32'd1);
        chk("beq_redirect", redirect_pc, 32'h180);
        chk("beq_br_count", br_count, 32'd1);
        chk("beq_mispred", mispred_count, 32'd1);
        chk("alloc_pred_taken", 32'(pred_taken), 32'd1);
        chk("alloc_pred_target", pred_target, 32'h180);
        tick();
        chk("flush_cyc2", 32'(flush), 32'd1);
        chk("pcsel_cyc2", 32'(pcsel), 32'd0);
        tick();
        chk("flush_done", 32'(flush), 32'd0);

        // Three correct taken predictions: counter saturates, no flush
        for (int i = 0; i < 3; i++) begin
            issue(OP_BR, 3'b000, 32'h100, 32'h180, 1'b1, 32'h180, 1'b1, 1'b0);
            chk("correct_no_flush", 32'(flush), 32'd0);
            chk("correct_no_pcsel", 32'(pcsel), 32'd0);
        end
        chk("br_count_4", br_count, 32'd4);
        chk("mispred_1", mispred_count, 32'd1);

        // Not taken once: ctr 11->10, still predicts taken; redirect to pc+4
        issue(OP_BR, 3'b000, 32'h100, 32'h180, 1'b1, 32'h180, 1'b0, 1'b0);
        chk("nt1_pcsel", 32'(pcsel), 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h104);
        chk("nt1_pred_taken", 32'(pred_taken), 32'd1);
        tick(); tick();
        // Not taken again: ctr 10->01, predicts not taken
        issue(OP_BR, 3'b000, 32'h100, 32'h180, 1'b1, 32'h180, 1'b0, 1'b0);
        chk("nt2_pred_taken", 32'(pred_taken), 32'd0);
        chk("nt2_pred_target", pred_target, 32'h104);
        chk("nt2_br_count", br_count, 32'd6);
        chk("nt2_mispred", mispred_count, 32'd3);
        tick(); tick();

        // BGEU taken (BrLT=0) correctly predicted: allocate, no flush
        if_pc = 32'h240;
        issue(OP_BR, 3'b111, 32'h240, 32'h200, 1'b1, 32'h200, 1'b0, 1'b0);
        chk("bgeu_no_flush", 32'(flush), 32'd0);
        chk("bgeu_no_pcsel", 32'(pcsel), 32'd0);
        chk("bgeu_br_count", br_count, 32'd7);
        chk("bgeu_pred_taken", 32'(pred_taken), 32'd1);
        chk("bgeu_pred_target", pred_target, 32'h200);
        // BGEU not taken (BrLT=1): redirect ex_pc+4
        issue(OP_BR, 3'b111, 32'h240, 32'h200, 1'b1, 32'h200, 1'b0, 1'b1);
        chk("bgeu_nt_pcsel", 32'(pcsel), 32'd1);
        chk("bgeu_nt_redirect", redirect_pc, 32'h244);
        chk("bgeu_nt_mispred", mispred_count, 32'd4);
        chk("bgeu_nt_pred_taken", 32'(pred_taken), 32'd0);
        tick(); tick();

        // funct3 010 and a non-branch with X comparators: no effect
        issue(OP_BR, 3'b010, 32'h240, 32'h200, 1'b0, 32'h244, 1'b1, 1'b1);
        issue(OP_ALU, 3'b000, 32'h240, 32'h200, 1'b0, 32'h244, 1'bx, 1'bx);
        chk("nonbranch_br_count", br_count, 32'd8);
        chk("nonbranch_flush", 32'(flush), 32'd0);
        chk("nonbranch_pred_taken", 32'(pred_taken), 32'd0);

        // BNE mispredict, then a branch during flush cycle 2 is ignored
        if_pc = 32'h300;
        issue(OP_BR, 3'b001, 32'h300, 32'h380, 1'b0, 32'h304, 1'b0, 1'b0);
        chk("bne_redirect", redirect_pc, 32'h380);
        chk("bne_br_count", br_count, 32'd9);
        tick();
        chk("bne_flush_cyc2", 32'(flush), 32'd1);
        issue(OP_BR, 3'b000, 32'h400, 32'h480, 1'b0, 32'h404, 1'b1, 1'b0);
        chk("ignored_flush_done", 32'(flush), 32'd0);
        chk("ignored_br_count", br_count, 32'd9);
        chk("ignored_mispred", mispred_count, 32'd5);
        if_pc = 32'h400;
        #1;
        chk("ignored_no_alloc", 32'(pred_taken), 32'd0);
        chk("ignored_target", pred_target, 32'h404);
        if_pc = 32'h300;
        #1;
        chk("bne_entry_kept", pred_target, 32'h380);

        // BLT mispredict, then async reset during flush
        if_pc = 32'h500;
        issue(OP_BR, 3'b100, 32'h500, 32'h520, 1'b0, 32'h504, 1'b0, 1'b1);
        chk("blt_flush", 32'(flush), 32'd1);
        chk("blt_pred_taken", 32'(pred_taken), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_pcsel", 32'(pcsel), 32'd0);
        chk("arst_redirect", redirect_pc, 32'd0);
        chk("arst_br_count", br_count, 32'd0);
        chk("arst_pred_taken", 32'(pred_taken), 32'd0);
        chk("arst_pred_target", pred_target, 32'h504);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_flush", 32'(flush), 32'd0);
        chk("post_rst_pcsel", 32'(pcsel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
